ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage 16-bit pipeline, directly upstream of the memory stage. It owns the ID/EX pipeline register. It resolves operand forwarding, runs the saturating ALU and computes branch targets. It maintains the architectural flag register (zr, neg, ov) and presents every field the memory stage latches: M, WB, flags, bcond, addr, wdata, PCbranch and ALU.

## Interface
- No parameters; data width fixed at 16.
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold ID/EX register; emit bubble downstream.
- flush  in  1  load bubble into ID/EX register; priority over stall.
- M_in  in  3  {branch, MemWrite, MemRead} from decode.
- WB_in  in  7  writeback control from decode, passed through.
- EXc_in  in  5  [2:0] aluop, [3] alusrc (1 = immediate as B), [4] fl_en.
- rdA_in, rdB_in  in  16  register-file read data.
- imm_in  in  16  sign-extended immediate or offset.
- pc1_in  in  16  PC+1 of the instruction.
- bcond_in  in  3  branch condition code, passed through.
- fwdA, fwdB  in  2  operand source: 0 = register file, 1 = mem_fwd, 2 = wb_fwd, 3 = register file.
- mem_fwd, wb_fwd  in  16  forwarded results from MEM and WB.
- M_out  out  3
- WB_out  out  7
- flags_out  out  3  {zr, neg, ov}.
- bcond_out  out  3
- addr_out  out  16
- wdata_out  out  16
- PCbranch_out  out  16
- ALU_out  out  16

## Operation
- **ID/EX register.** Holds M, WB, EXc, rdA, rdB, imm, pc1 and bcond.
  - Reset: all zero.
  - flush: loads zero (bubble).
  - stall without flush: holds its contents.
  - Otherwise: loads the *_in values.
- **Operand selection.**
  - A = fwdA-selected value.
  - Bsrc = fwdB-selected value.
  - B = imm when alusrc, else Bsrc.
- **ALU operations** (aluop):
  - ADD = 0 and SUB = 1: two's-complement, saturating. Positive overflow gives 0x7FFF, negative overflow gives 0x8000, and ov = 1.
  - AND = 2, NOR = 3.
  - SLL = 4, SRL = 5, SRA = 6: shift amount is B[3:0].
  - LHB = 7: result = {B[7:0], A[7:0]}.
- **Flag update** (only when fl_en):
  - ADD/SUB update zr, neg and ov.
  - AND/NOR/shifts update zr only; neg and ov retain their old values.
  - LHB updates none.
  - zr = (result == 0); neg = result[15].
- **flags_out** is the combinational next-flag value, so a branch immediately following a flag-setting instruction sees the new flags.
- **Flag register** loads next-flag on posedge only when !stall. Reset value is 0.
- **Output assignments:**
  - ALU_out = addr_out = result.
  - wdata_out = Bsrc (store data, forwarded).
  - PCbranch_out = pc1 + imm, wrapping mod 2^16.
  - bcond_out = registered bcond.
- **Stall bubble.** While stall = 1, M_out = 0 and WB_out = 0. The other outputs still reflect the held instruction, which is harmless.

## Timing
- Inputs sampled at edge N; outputs valid combinationally in cycle N+1; MEM latches them at edge N+1.
- The flag register commits at the same edge N+1, so a second cycle under stall cannot double-apply.
- flush and stall together: bubble loaded; flag register unchanged that edge.
- A bubble has EXc = 0, so fl_en = 0. Flags pass through unchanged and M/WB are 0.
- Reset mid-operation: the register and flags clear immediately (asynchronous). Outputs read zero until the first load after rst_n rises.
- Saturation is checked on the 17-bit signed result. SUB 0x8000 − 1 gives 0x8000 with ov = 1.

## Structure
- Shared package ex_pkg:
  - aluop_t enum (ADD..LHB).
  - fwd_t enum (FWD_RF, FWD_MEM, FWD_WB).
  - Flag index constants FL_ZR = 2, FL_NEG = 1, FL_OV = 0.
  - EXc field positions.
- The memory stage shares the flag indices from ex_pkg.
- One combinational sub-module, ex_alu: inputs A, B, aluop; outputs result, zr, neg, ov.
- ex_stage holds the registers, the forwarding muxes, the flag-merge logic and the branch adder.

## Test plan
- **Reset:** rst_n = 0 with random inputs → all outputs 0, flags_out = 000. After release and a NOP, flags_out = 000.
- **Saturation:** ADD with rdA = 0x7FFF, imm = 1, alusrc = 1, fl_en = 1 → ALU_out = 0x7FFF, flags_out = 001. Next SUB 0x8000 − 0x0001 → 0x8000, flags_out = 011.
- **Partial flag update:** SUB 5 − 5 → ALU_out = 0, flags 100. Then SUB 3 − 5 → 0xFFFE, flags 010. Then AND 0xF0F0 & 0x0F0F → 0, flags 110 (neg retained).
- **Forwarding:**
  - fwdA = 1, mem_fwd = 0x1234, fwdB = 2, wb_fwd = 0x0001, ADD → 0x1235.
  - SW with fwdB = 1 → wdata_out = mem_fwd, addr_out = A + imm.
- **Stall:**
  - Stall for 2 cycles during an ADD with fl_en → M_out = WB_out = 0 both cycles; flag register unchanged.
  - On release → the ADD's real M/WB appear once; flags commit once.
- **Flush and branch target:**
  - flush and stall together → next cycle M_out = 0, WB_out = 0, flags held.
  - Branch with pc1 = 0xFFFF, imm = 0x0002 → PCbranch_out = 0x0001.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage and its neighbours.
//   aluop_t     - ALU operation encoding carried in EXc[2:0]
//   fwd_t       - operand source select encoding (value 3 also means register file)
//   FL_*        - bit positions of {zr, neg, ov} in every flag vector
//   EXC_*       - field positions inside the 5-bit EXc control word
//   fwd_select  - forwarding mux shared by both operand paths
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_NOR = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_LHB = 3'd7
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_t;

  localparam int FL_ZR  = 2;
  localparam int FL_NEG = 1;
  localparam int FL_OV  = 0;

  localparam int EXC_OP_MSB = 2;
  localparam int EXC_ALUSRC = 3;
  localparam int EXC_FLEN   = 4;

  // Select 3 is unused by decode and falls back to the register file.
  function automatic logic [15:0] fwd_select(input logic [1:0]  sel,
                                             input logic [15:0] rf,
                                             input logic [15:0] mem,
                                             input logic [15:0] wb);
    logic [15:0] val;
    case (sel)
      FWD_MEM: val = mem;
      FWD_WB:  val = wb;
      default: val = rf;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// ex_alu: purely combinational 16-bit ALU with saturating add/subtract.
//   a, b    in  16  operands
//   aluop   in  3   operation (aluop_t)
//   result  out 16  operation result
//   zr      out 1   result == 0
//   neg     out 1   result[15]
//   ov      out 1   add/sub saturated (always 0 for other operations)
module ex_alu
  import ex_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  aluop_t      aluop,
  output logic [15:0] result,
  output logic        zr,
  output logic        neg,
  output logic        ov
);

  logic [16:0] sum;

  // Add/sub run on sign-extended 17-bit operands. When the top two bits of
  // the 17-bit sum disagree the true value no longer fits in 16 bits, and
  // bit 16 tells us which rail to clamp to.
  always_comb begin
    sum    = '0;
    result = '0;
    ov     = 1'b0;
    case (aluop)
      ALU_ADD, ALU_SUB: begin
        if (aluop == ALU_SUB)
          sum = {a[15], a} - {b[15], b};
        else
          sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15]) begin
          ov     = 1'b1;
          result = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
          result = sum[15:0];
        end
      end
      ALU_AND: result = a & b;
      ALU_NOR: result = ~(a | b);
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
      ALU_SRA: result = $signed(a) >>> b[3:0];
      default: result = {b[7:0], a[7:0]};
    endcase
  end

  assign zr  = (result == 16'h0000);
  assign neg = result[15];

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline. Owns the ID/EX register
// and the architectural flag register, resolves operand forwarding, runs the
// ALU and forms the branch target.
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          hold ID/EX / load a bubble (flush wins)
//   M_in, WB_in, EXc_in   control from decode
//   rdA_in, rdB_in        register-file operands
//   imm_in, pc1_in        immediate/offset and PC+1
//   bcond_in              branch condition code
//   fwdA, fwdB            operand source selects
//   mem_fwd, wb_fwd       forwarded results from MEM and WB
//   M_out .. ALU_out      fields latched by the memory stage
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  M_in,
  input  logic [6:0]  WB_in,
  input  logic [4:0]  EXc_in,
  input  logic [15:0] rdA_in,
  input  logic [15:0] rdB_in,
  input  logic [15:0] imm_in,
  input  logic [15:0] pc1_in,
  input  logic [2:0]  bcond_in,
  input  logic [1:0]  fwdA,
  input  logic [1:0]  fwdB,
  input  logic [15:0] mem_fwd,
  input  logic [15:0] wb_fwd,
  output logic [2:0]  M_out,
  output logic [6:0]  WB_out,
  output logic [2:0]  flags_out,
  output logic [2:0]  bcond_out,
  output logic [15:0] addr_out,
  output logic [15:0] wdata_out,
  output logic [15:0] PCbranch_out,
  output logic [15:0] ALU_out
);

  logic [2:0]  m_q;
  logic [6:0]  wb_q;
  logic [4:0]  exc_q;
  logic [15:0] rda_q, rdb_q, imm_q, pc1_q;
  logic [2:0]  bcond_q;
  logic [2:0]  flags_q;
  logic        loaded_q;

  logic [15:0] op_a, op_bsrc, op_b;
  logic [15:0] alu_result;
  logic        alu_zr, alu_neg, alu_ov;
  aluop_t      alu_op;
  logic [2:0]  next_flags;

  // ID/EX register: flush drops a bubble in, stall freezes the instruction,
  // otherwise decode's fields advance into execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      wb_q    <= '0;
      exc_q   <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      imm_q   <= '0;
      pc1_q   <= '0;
      bcond_q <= '0;
    end else if (flush) begin
      m_q     <= '0;
      wb_q    <= '0;
      exc_q   <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      imm_q   <= '0;
      pc1_q   <= '0;
      bcond_q <= '0;
    end else if (!stall) begin
      m_q     <= M_in;
      wb_q    <= WB_in;
      exc_q   <= EXc_in;
      rda_q   <= rdA_in;
      rdb_q   <= rdB_in;
      imm_q   <= imm_in;
      pc1_q   <= pc1_in;
      bcond_q <= bcond_in;
    end
  end

  // Remembers whether the register has been written since reset. Until then
  // the forwarding inputs may carry junk, so the data outputs are held at
  // zero rather than showing whatever the forwarding muxes pick up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      loaded_q <= 1'b0;
    else if (flush || !stall)
      loaded_q <= 1'b1;
  end

  // Flags commit as the instruction leaves execute, which is exactly the
  // edge where stall is low. A stalled (or stalled-and-flushed) instruction
  // therefore never touches the architectural flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flags_q <= '0;
    else if (!stall)
      flags_q <= next_flags;
  end

  assign op_a    = fwd_select(fwdA, rda_q, mem_fwd, wb_fwd);
  assign op_bsrc = fwd_select(fwdB, rdb_q, mem_fwd, wb_fwd);
  assign op_b    = exc_q[EXC_ALUSRC] ? imm_q : op_bsrc;
  assign alu_op  = aluop_t'(exc_q[EXC_OP_MSB:0]);

  ex_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .aluop  (alu_op),
    .result (alu_result),
    .zr     (alu_zr),
    .neg    (alu_neg),
    .ov     (alu_ov)
  );

  // Flag merge: arithmetic rewrites all three flags, logic and shift ops
  // only rewrite zr, and LHB leaves everything alone.
  always_comb begin
    next_flags = flags_q;
    if (exc_q[EXC_FLEN]) begin
      case (alu_op)
        ALU_ADD, ALU_SUB: begin
          next_flags[FL_ZR]  = alu_zr;
          next_flags[FL_NEG] = alu_neg;
          next_flags[FL_OV]  = alu_ov;
        end
        ALU_AND, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA:
          next_flags[FL_ZR] = alu_zr;
        default: ;
      endcase
    end
  end

  assign flags_out    = next_flags;
  assign M_out        = stall ? 3'b000 : m_q;
  assign WB_out       = stall ? 7'b0 : wb_q;
  assign bcond_out    = bcond_q;
  assign ALU_out      = loaded_q ? alu_result : 16'h0000;
  assign addr_out     = loaded_q ? alu_result : 16'h0000;
  assign wdata_out    = loaded_q ? op_bsrc : 16'h0000;
  assign PCbranch_out = pc1_q + imm_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. A reference model of the
// ID/EX contents and flag register predicts every output each cycle, and a
// directed script pins known values before a randomized run.
module tb_ex_stage;

  typedef struct packed {
    logic [2:0]  m;
    logic [6:0]  wb;
    logic [4:0]  exc;
    logic [15:0] rda;
    logic [15:0] rdb;
    logic [15:0] imm;
    logic [15:0] pc1;
    logic [2:0]  bcond;
  } instr_t;

  typedef struct packed {
    logic [2:0]  m;
    logic [6:0]  wb;
    logic [2:0]  flags;
    logic [2:0]  bcond;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pcb;
    logic [15:0] alu;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [2:0]  M_in;
  logic [6:0]  WB_in;
  logic [4:0]  EXc_in;
  logic [15:0] rdA_in, rdB_in, imm_in, pc1_in;
  logic [2:0]  bcond_in;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] mem_fwd, wb_fwd;
  logic [2:0]  M_out, flags_out, bcond_out;
  logic [6:0]  WB_out;
  logic [15:0] addr_out, wdata_out, PCbranch_out, ALU_out;

  int n_checks = 0;
  int n_fail   = 0;

  instr_t     mreg;
  logic [2:0] mflags;
  bit         mloaded;

  ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .M_in         (M_in),
    .WB_in        (WB_in),
    .EXc_in       (EXc_in),
    .rdA_in       (rdA_in),
    .rdB_in       (rdB_in),
    .imm_in       (imm_in),
    .pc1_in       (pc1_in),
    .bcond_in     (bcond_in),
    .fwdA         (fwdA),
    .fwdB         (fwdB),
    .mem_fwd      (mem_fwd),
    .wb_fwd       (wb_fwd),
    .M_out        (M_out),
    .WB_out       (WB_out),
    .flags_out    (flags_out),
    .bcond_out    (bcond_out),
    .addr_out     (addr_out),
    .wdata_out    (wdata_out),
    .PCbranch_out (PCbranch_out),
    .ALU_out      (ALU_out)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [2:0] m, input logic [6:0] wb,
                                input logic [4:0] exc, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] imm,
                                input logic [15:0] pc1, input logic [2:0] bc);
    instr_t x;
    x.m = m; x.wb = wb; x.exc = exc; x.rda = a; x.rdb = b;
    x.imm = imm; x.pc1 = pc1; x.bcond = bc;
    return x;
  endfunction

  function automatic instr_t randInstr();
    return mk(3'($urandom), 7'($urandom), 5'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
  endfunction

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] rf);
    if (sel == 2'd1) return mem_fwd;
    if (sel == 2'd2) return wb_fwd;
    return rf;
  endfunction

  // Reference: derive every output from the modelled EX instruction, the
  // modelled flags and the live forwarding inputs using plain integer math.
  function automatic out_t modelOut();
    out_t        o;
    logic [15:0] a, bsrc, b, r;
    logic [2:0]  op, f;
    logic        ovf;
    int          ai, bi, s;
    a    = pick(fwdA, mreg.rda);
    bsrc = pick(fwdB, mreg.rdb);
    b    = mreg.exc[3] ? mreg.imm : bsrc;
    op   = mreg.exc[2:0];
    ovf  = 1'b0;
    r    = '0;
    ai   = $signed(a);
    bi   = $signed(b);
    case (op)
      3'd0, 3'd1: begin
        s = (op == 3'd0) ? ai + bi : ai - bi;
        if (s > 32767) begin r = 16'h7FFF; ovf = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; ovf = 1'b1; end
        else r = s[15:0];
      end
      3'd2: r = a & b;
      3'd3: r = ~(a | b);
      3'd4: r = a << b[3:0];
      3'd5: r = a >> b[3:0];
      3'd6: r = 16'($signed(a) >>> b[3:0]);
      default: r = {b[7:0], a[7:0]};
    endcase
    f = mflags;
    if (mreg.exc[4]) begin
      if (op <= 3'd1) f = {(r == 16'h0), r[15], ovf};
      else if (op <= 3'd6) f[2] = (r == 16'h0);
    end
    o.m     = stall ? 3'b0 : mreg.m;
    o.wb    = stall ? 7'b0 : mreg.wb;
    o.flags = f;
    o.bcond = mreg.bcond;
    o.alu   = mloaded ? r : 16'h0;
    o.addr  = mloaded ? r : 16'h0;
    o.wdata = mloaded ? bsrc : 16'h0;
    o.pcb   = mreg.pc1 + mreg.imm;
    return o;
  endfunction

  task automatic modelReset();
    mreg    = '0;
    mflags  = '0;
    mloaded = 0;
  endtask

  // Advance the model across a clock edge using the inputs held before it.
  task automatic modelEdge();
    out_t e;
    if (rst_n) begin
      e = modelOut();
      if (!stall) mflags = e.flags;
      if (flush) mreg = '0;
      else if (!stall)
        mreg = mk(M_in, WB_in, EXc_in, rdA_in, rdB_in, imm_in, pc1_in, bcond_in);
      if (flush || !stall) mloaded = 1;
    end
  endtask

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    out_t e;
    e = modelOut();
    checkVal("M_out",        16'(M_out),        16'(e.m));
    checkVal("WB_out",       16'(WB_out),       16'(e.wb));
    checkVal("flags_out",    16'(flags_out),    16'(e.flags));
    checkVal("bcond_out",    16'(bcond_out),    16'(e.bcond));
    checkVal("addr_out",     addr_out,          e.addr);
    checkVal("wdata_out",    wdata_out,         e.wdata);
    checkVal("PCbranch_out", PCbranch_out,      e.pcb);
    checkVal("ALU_out",      ALU_out,           e.alu);
  endtask

  task automatic applyStimulus(input instr_t ins, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [15:0] mf, input logic [15:0] wf,
                               input logic st, input logic fl);
    M_in = ins.m; WB_in = ins.wb; EXc_in = ins.exc;
    rdA_in = ins.rda; rdB_in = ins.rdb; imm_in = ins.imm;
    pc1_in = ins.pc1; bcond_in = ins.bcond;
    fwdA = fa; fwdB = fb; mem_fwd = mf; wb_fwd = wf;
    stall = st; flush = fl;
  endtask

  // Drive the next cycle's inputs (which also carry forwarding for the
  // instruction now in EX), let them settle and compare against the model.
  task automatic settle(input instr_t ins, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [15:0] mf, input logic [15:0] wf,
                        input logic st, input logic fl);
    applyStimulus(ins, fa, fb, mf, wf, st, fl);
    #1;
    checkOutput();
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Opcode words: {fl_en, alusrc, aluop}
  instr_t nop, add_sat, sub_sat, sub55, sub35, and_op, fwd_add, sw, st_add, br;

  initial begin
    nop     = '0;
    add_sat = mk(3'b000, 7'h00, 5'b11000, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 3'b000);
    sub_sat = mk(3'b000, 7'h00, 5'b11001, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 3'b000);
    sub55   = mk(3'b000, 7'h00, 5'b10001, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b000);
    sub35   = mk(3'b000, 7'h00, 5'b10001, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 3'b000);
    and_op  = mk(3'b000, 7'h00, 5'b10010, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 3'b000);
    fwd_add = mk(3'b000, 7'h00, 5'b00000, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 3'b000);
    sw      = mk(3'b010, 7'h00, 5'b01000, 16'h0100, 16'h7777, 16'h0004, 16'h0000, 3'b000);
    st_add  = mk(3'b001, 7'h55, 5'b10000, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 3'b000);
    br      = mk(3'b100, 7'h00, 5'b00000, 16'h0000, 16'h0000, 16'h0002, 16'hFFFF, 3'b101);

    // Reset held with random inputs: everything must read zero.
    rst_n = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      settle(randInstr(), 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom));
      checkVal("reset ALU_out", ALU_out, 16'h0000);
      checkVal("reset M_out", 16'(M_out), 16'h0000);
      checkVal("reset flags_out", 16'(flags_out), 16'h0000);
      cycle();
    end
    rst_n = 1'b1;
    settle(nop, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    cycle();

    settle(add_sat, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("flags after reset NOP", 16'(flags_out), 16'h0000);
    cycle();
    settle(sub_sat, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("ADD sat ALU", ALU_out, 16'h7FFF);
    checkVal("ADD sat flags", 16'(flags_out), 16'h0001);
    cycle();
    settle(sub55, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("SUB sat ALU", ALU_out, 16'h8000);
    checkVal("SUB sat flags", 16'(flags_out), 16'h0003);
    cycle();
    settle(sub35, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("SUB 5-5 ALU", ALU_out, 16'h0000);
    checkVal("SUB 5-5 flags", 16'(flags_out), 16'h0004);
    cycle();
    settle(and_op, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("SUB 3-5 ALU", ALU_out, 16'hFFFE);
    checkVal("SUB 3-5 flags", 16'(flags_out), 16'h0002);
    cycle();
    settle(fwd_add, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("AND ALU", ALU_out, 16'h0000);
    checkVal("AND flags neg kept", 16'(flags_out), 16'h0006);
    cycle();
    settle(sw, 2'd1, 2'd2, 16'h1234, 16'h0001, 1'b0, 1'b0);
    checkVal("fwd ADD ALU", ALU_out, 16'h1235);
    cycle();
    settle(st_add, 2'd0, 2'd1, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    checkVal("SW wdata", wdata_out, 16'hBEEF);
    checkVal("SW addr", addr_out, 16'h0104);
    checkVal("SW M_out", 16'(M_out), 16'h0002);
    cycle();

    // Two stall cycles on an ADD, then release.
    for (int i = 0; i < 2; i++) begin
      settle(nop, 2'd0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      checkVal("stall M_out", 16'(M_out), 16'h0000);
      checkVal("stall WB_out", 16'(WB_out), 16'h0000);
      checkVal("stall ALU", ALU_out, 16'h0003);
      cycle();
    end
    settle(sub55, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("release M_out", 16'(M_out), 16'h0001);
    checkVal("release WB_out", 16'(WB_out), 16'h0055);
    checkVal("release flags", 16'(flags_out), 16'h0000);
    cycle();

    // Flush and stall together on a flag-setting SUB: flags must not commit.
    settle(nop, 2'd0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    checkVal("flush+stall M_out", 16'(M_out), 16'h0000);
    checkVal("flush+stall next flags", 16'(flags_out), 16'h0004);
    cycle();
    settle(br, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("bubble M_out", 16'(M_out), 16'h0000);
    checkVal("bubble WB_out", 16'(WB_out), 16'h0000);
    checkVal("bubble flags held", 16'(flags_out), 16'h0000);
    cycle();
    settle(nop, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkVal("branch target wrap", PCbranch_out, 16'h0001);
    checkVal("branch M_out", 16'(M_out), 16'h0004);
    checkVal("branch bcond", 16'(bcond_out), 16'h0005);
    cycle();

    // Randomized run, including occasional mid-operation resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(79) == 0) begin
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        checkVal("mid reset ALU_out", ALU_out, 16'h0000);
        rst_n = 1'b1;
      end
      settle(randInstr(), 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
             ($urandom_range(4) == 0), ($urandom_range(9) == 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
